pll_lock_supervisor: RTL

- Sequences the SDRAM-domain rPLL: drives the PLL RESET pin, qualifies LOCK, and holds the downstream system reset until lock has been stable.
- Runs on the 27 MHz board reference clock, i.e. the PLL input clock, never the PLL output.
- Retries on lock timeout and re-locks on lock loss.
- Escalates to a sticky fault after repeated failures.

---
 rtl/pll_lock_supervisor.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Sequences the SDRAM-domain rPLL from the 27 MHz board reference clock (the
// PLL input clock, never its output). It pulses the PLL RESET pin, qualifies
// the asynchronous LOCK signal and holds the downstream system reset until
// lock has been stable. It retries when lock times out and re-locks when lock
// is lost. After MAX_RETRIES consecutive timeouts it parks in a sticky FAULT.
//
// Ports:
//   clk          27 MHz reference clock, same net as the PLL clkin
//   rst          asynchronous, active-high reset
//   pll_lock     PLL LOCK output, asynchronous to clk
//   restart      single-cycle request to force a full re-lock sequence
//   pll_reset    to the PLL RESET pin, high = PLL held in reset
//   sys_rst      active-high reset for SDRAM-domain logic
//   ready        high while in RUN
//   fault        high while in FAULT
//   state        encoded state: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAULT
//   retry_count  consecutive lock timeouts since the last RUN or restart
//   loss_count   lock-loss events while in RUN, saturating at 255
//
// Handshake: there is no valid/ready pair on this block. restart is a level
// sampled on every rising clk edge; a one-cycle pulse is a single request,
// and holding it high keeps the sequencer pinned in PLL_RST. restart
// outranks every lock event and every timer expiry.
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 27000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [3:0] retry_count,
  output logic [7:0] loss_count
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  // Terminal timer values: the timer counts 0..N-1 while in a state, so the
  // state lasts exactly N cycles when it leaves on the N-1 match.
  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);

  state_t      state_r;
  state_t      state_n;
  logic        lock_meta;
  logic        lock_s;
  logic [15:0] timer;
  logic [15:0] timer_n;
  logic [3:0]  retry_n;
  logic [7:0]  loss_n;
  logic        enter;
  logic [3:0]  retry_inc;

  // Two-flop synchronizer for the asynchronous LOCK pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  assign retry_inc = retry_count + 4'd1;

  // Next-state, counter and timer logic. 'enter' marks any state entry,
  // including a restart taken while already in PLL_RST, so the timer always
  // restarts from zero when a state is (re)entered.
  always_comb begin
    state_n = state_r;
    retry_n = retry_count;
    loss_n  = loss_count;
    enter   = 1'b0;

    if (restart) begin
      state_n = S_PLL_RST;
      retry_n = 4'd0;
      enter   = 1'b1;
    end else begin
      unique case (state_r)
        S_PLL_RST: begin
          if (timer == RST_LAST) begin
            state_n = S_WAIT_LOCK;
            enter   = 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_n = S_STABLE;
            enter   = 1'b1;
          end else if (timer == LOCK_LAST) begin
            retry_n = retry_inc;
            state_n = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_PLL_RST;
            enter   = 1'b1;
          end
        end
        S_STABLE: begin
          // A drop here is not a timeout: go back for a fresh lock window
          // without charging a retry.
          if (!lock_s) begin
            state_n = S_WAIT_LOCK;
            enter   = 1'b1;
          end else if (timer == STABLE_LAST) begin
            state_n = S_RUN;
            retry_n = 4'd0;
            enter   = 1'b1;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_n = S_PLL_RST;
            loss_n  = (loss_count == 8'hFF) ? loss_count : loss_count + 8'd1;
            enter   = 1'b1;
          end
        end
        S_FAULT: begin
          state_n = S_FAULT;
        end
        default: begin
          state_n = S_PLL_RST;
          enter   = 1'b1;
        end
      endcase
    end

    if (enter) begin
      timer_n = 16'd0;
    end else if ((state_r == S_PLL_RST) || (state_r == S_WAIT_LOCK) ||
                 (state_r == S_STABLE)) begin
      timer_n = timer + 16'd1;
    end else begin
      timer_n = timer;
    end
  end

  // State, counters and outputs. Outputs are decoded from the next state so
  // they move on the same edge as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_PLL_RST;
      timer       <= 16'd0;
      retry_count <= 4'd0;
      loss_count  <= 8'd0;
      pll_reset   <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_r     <= state_n;
      timer       <= timer_n;
      retry_count <= retry_n;
      loss_count  <= loss_n;
      pll_reset   <= (state_n == S_PLL_RST) || (state_n == S_FAULT);
      sys_rst     <= (state_n != S_RUN);
      ready       <= (state_n == S_RUN);
      fault       <= (state_n == S_FAULT);
    end
  end

  assign state = state_r;

endmodule
